lfsr_rng_arbiter: RTL and testbench

- Shares one 5-bit maximal-length LFSR random source among NREQ requesters.
- Arbitrates pending requests, advances the LFSR a fixed number of steps per grant, and hands the fresh word to the winner with a one-cycle ack.
- Supports synchronous reseeding while idle.
- Sits between the LFSR datapath and the client blocks that consume pseudo-random words.

---
 rtl/lfsr_rng_arbiter_if.sv | 29 ++
 rtl/lfsr_rng_arbiter.sv | 146 ++++++++++++++
 tb/tb_lfsr_rng_arbiter.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_arbiter_if.sv
// Request/delivery bundle between client blocks and lfsr_rng_arbiter.
// Handshake: a client raises req[i] and holds it until it sees ack[i].
// ack[i] is a one-cycle strobe that coincides with rnd_vld. The client must
// drop req[i] before the next rising edge after the ack cycle, otherwise the
// still-high bit is taken as a fresh request. seed_ld is a single-cycle
// command that only has effect while busy is low.
interface lfsr_rng_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
);
  logic [NREQ-1:0] req;
  logic            seed_ld;
  logic [4:0]      seed;
  logic [NREQ-1:0] ack;
  logic [4:0]      rnd;
  logic            rnd_vld;
  logic [IDXW-1:0] gnt_idx;
  logic            busy;

  modport master (
    output req, seed_ld, seed,
    input  ack, rnd, rnd_vld, gnt_idx, busy
  );

  modport slave (
    input  req, seed_ld, seed,
    output ack, rnd, rnd_vld, gnt_idx, busy
  );
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// Shares one 5-bit maximal-length LFSR among NREQ requesters. A granted
// requester waits STEPS LFSR advances, then receives the fresh word with a
// one-cycle ack. Reseeding is accepted only while idle.
// Build option: define LFSR_ARB_RR_EN for round-robin arbitration; without
// it the lowest asserted req index wins (fixed priority, no pointer state).
module lfsr_rng_arbiter #(
  parameter int NREQ  = 4,
  parameter int STEPS = 5,
  parameter int IDXW  = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  lfsr_rng_arbiter_if.slave  bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STEP    = 2'd1,
    ST_DELIVER = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      lfsr_q, lfsr_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic [4:0]      rnd_q, rnd_d;
  logic [IDXW-1:0] win_idx;
  logic            any_req;
  logic [4:0]      lfsr_nxt;

  // One Galois-free Fibonacci step, taps 5 and 3 (x^5 + x^3 + 1).
  assign lfsr_nxt = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  assign any_req  = |bus.req;

`ifdef LFSR_ARB_RR_EN
  logic [IDXW-1:0] ptr_q, ptr_d;

  // Round-robin winner: first asserted req searching upward from ptr_q.
  always_comb begin
    logic            found;
    logic [IDXW-1:0] cand;
    win_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDXW'((int'(ptr_q) + i) % NREQ);
      if (!found && bus.req[cand]) begin
        win_idx = cand;
        found   = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner on every grant.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && !bus.seed_ld && any_req) begin
      ptr_d = IDXW'((int'(win_idx) + 1) % NREQ);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  // Fixed priority winner: lowest asserted index.
  always_comb begin
    logic [IDXW-1:0] cand;
    win_idx = '0;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = IDXW'(i);
      if (bus.req[cand]) win_idx = cand;
    end
  end
`endif

  // Next-state, LFSR, counter and delivery-word logic.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    gnt_idx_d = gnt_idx_q;
    rnd_d     = rnd_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.seed_ld) begin
          // A zero seed would lock the LFSR; coerce it to all-ones.
          lfsr_d = (bus.seed == 5'd0) ? 5'h1F : bus.seed;
        end else if (any_req) begin
          gnt_idx_d = win_idx;
          cnt_d     = 5'd0;
          state_d   = ST_STEP;
        end
      end
      ST_STEP: begin
        lfsr_d = lfsr_nxt;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(STEPS - 1)) begin
          // Capture the word on entry so rnd equals the LFSR in DELIVER.
          rnd_d   = lfsr_nxt;
          state_d = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= 5'h1F;
      cnt_q     <= 5'd0;
      gnt_idx_q <= '0;
      rnd_q     <= 5'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      gnt_idx_q <= gnt_idx_d;
      rnd_q     <= rnd_d;
    end
  end

  // Delivery strobes decode directly from the DELIVER state.
  always_comb begin
    bus.ack = '0;
    if (state_q == ST_DELIVER) bus.ack[gnt_idx_q] = 1'b1;
  end

  assign bus.rnd     = rnd_q;
  assign bus.rnd_vld = (state_q == ST_DELIVER);
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter (NREQ=4, STEPS=5). Expected words are
// hand-derived from the LFSR sequence 1F,1E,1C,18,11,03,06,0D,1B,17,0E,1D,
// 1A,15,0A,14,08,10,01,02,04 and, from seed 01, 02,04,09,12,05.
module tb_lfsr_rng_arbiter;

  localparam int NREQ  = 4;
  localparam int STEPS = 5;
  localparam int IDXW  = 2;
  localparam int LAT   = STEPS + 1;  // rising edges from IDLE sample to ack

  logic       clk;
  logic       rst_b;
  logic [1:0] dbg_state;

  int n_checks;
  int n_errors;
  logic [4:0] exp_q[$];

  lfsr_rng_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

  lfsr_rng_arbiter #(.NREQ(NREQ), .STEPS(STEPS), .IDXW(IDXW)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_seed(input logic [4:0] s);
    bus.seed_ld = 1'b1;
    bus.seed    = s;
    tick();
    bus.seed_ld = 1'b0;
  endtask

  // Waits for the next ack, checks latency, busy, word and index, then checks
  // the strobe is single-cycle and the word is held afterwards.
  task automatic expect_delivery(input string tag, input logic [4:0] exp_rnd,
                                 input int exp_idx, input int exp_lat, input bit drop);
    int cyc;
    int busy_n;
    logic [NREQ-1:0] exp_ack;
    cyc    = 0;
    busy_n = 0;
    while (cyc < 40 && bus.ack == '0) begin
      tick();
      cyc++;
      if (bus.busy) busy_n++;
    end
    exp_ack = '0;
    exp_ack[exp_idx] = 1'b1;
    check({tag, "_lat"},     cyc,          exp_lat);
    check({tag, "_busy"},    busy_n,       exp_lat);
    check({tag, "_ack"},     bus.ack,      exp_ack);
    check({tag, "_rnd"},     bus.rnd,      exp_rnd);
    check({tag, "_vld"},     bus.rnd_vld,  1);
    check({tag, "_gnt"},     bus.gnt_idx,  exp_idx);
    if (drop) bus.req[exp_idx] = 1'b0;
    tick();
    check({tag, "_ack_off"}, bus.ack,      0);
    check({tag, "_vld_off"}, bus.rnd_vld,  0);
    check({tag, "_hold"},    bus.rnd,      exp_rnd);
    check({tag, "_idle"},    bus.busy,     0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_b       = 1'b0;
    bus.req     = '0;
    bus.seed_ld = 1'b0;
    bus.seed    = 5'd0;
    repeat (2) @(negedge clk);

    // Reset values.
    check("rst_ack",  bus.ack,     0);
    check("rst_rnd",  bus.rnd,     0);
    check("rst_vld",  bus.rnd_vld, 0);
    check("rst_gnt",  bus.gnt_idx, 0);
    check("rst_busy", bus.busy,    0);
    rst_b = 1'b1;
    tick();

    // Single requests from the reset LFSR value.
    bus.req[0] = 1'b1;
    expect_delivery("req0_a", 5'h03, 0, LAT, 1'b1);
    bus.req[0] = 1'b1;
    expect_delivery("req0_b", 5'h0E, 0, LAT, 1'b1);

    // Seed load wins over a simultaneous request.
    bus.seed_ld = 1'b1;
    bus.seed    = 5'h01;
    bus.req[2]  = 1'b1;
    tick();
    bus.seed_ld = 1'b0;
    check("seed_prio", bus.busy, 0);
    expect_delivery("seed01", 5'h05, 2, LAT, 1'b1);

    // Zero seed is coerced to 1F.
    do_seed(5'h00);
    bus.req[1] = 1'b1;
    expect_delivery("seed00", 5'h03, 1, LAT, 1'b1);

    // Seed load during STEP is ignored.
    do_seed(5'h00);
    bus.req[0] = 1'b1;
    tick();
    tick();
    bus.seed_ld = 1'b1;
    bus.seed    = 5'h0A;
    tick();
    bus.seed_ld = 1'b0;
    expect_delivery("seed_busy", 5'h03, 0, LAT - 3, 1'b1);

    // Reset in the middle of STEP.
    bus.req[1] = 1'b1;
    tick();
    tick();
    check("mid_busy", bus.busy, 1);
    rst_b = 1'b0;
    #1;
    check("mid_rst_ack",  bus.ack,     0);
    check("mid_rst_rnd",  bus.rnd,     0);
    check("mid_rst_vld",  bus.rnd_vld, 0);
    check("mid_rst_gnt",  bus.gnt_idx, 0);
    check("mid_rst_busy", bus.busy,    0);
    bus.req[1] = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_ack", bus.ack, 0);
    end
    bus.req[3] = 1'b1;
    expect_delivery("post_rst", 5'h03, 3, LAT, 1'b1);

    // All four request together; each drops after its own ack.
    do_seed(5'h00);
    exp_q.push_back(5'h03);
    exp_q.push_back(5'h0E);
    exp_q.push_back(5'h14);
    exp_q.push_back(5'h04);
    bus.req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      expect_delivery("sweep", exp_q.pop_front(), i, LAT, 1'b1);
    end

    // Requester 0 keeps its request high.
    do_seed(5'h00);
    bus.req = 4'b0011;
    expect_delivery("hold_a", 5'h03, 0, LAT, 1'b0);
`ifdef LFSR_ARB_RR_EN
    expect_delivery("hold_b", 5'h0E, 1, LAT, 1'b1);
`else
    expect_delivery("hold_b", 5'h0E, 0, LAT, 1'b1);
`endif
    bus.req = '0;
    tick();
    tick();
    check("final_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
